// File: rtl/wb_stream_writer.sv
// wb_stream_writer
//   Reads a memory buffer over a Wishbone B3 burst master and replays it as a
//   valid/ready word stream. A small Wishbone slave holds the configuration.
//
//   Registers (byte offsets on wbs_adr_i):
//     0  CSR        bit0 busy (write 1 starts), bit1 irq (write 1 clears),
//                   bit2 bus error (write 1 clears)
//     4  START_ADDR byte address of the buffer
//     8  BUF_SIZE   buffer length in bytes
//     12 BURST_SIZE words per burst (0 -> 1, above MAX_BURST_LEN -> MAX_BURST_LEN)
//
//   Ports
//     clk, rst            clock, asynchronous active-low reset
//     wbm_*               Wishbone burst read master (classic incrementing)
//     stream_m_*          stream output, data = output FIFO head
//     irq_o               mirrors CSR bit1
//     wbs_*               Wishbone configuration slave
//
//   Optional feature: define WB_STREAM_WRITER_ERR_EN to make wbm_err_i abort
//   the transfer (CSR bit2 + irq, FIFO flushed). Without it wbm_err_i is ignored.
//   WB_AW must not exceed WB_DW (START_ADDR is written from wbs_dat_i).
module wb_stream_writer #(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 5,
    parameter int MAX_BURST_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    output logic [WB_DW-1:0]     stream_m_data_o,
    output logic                 stream_m_valid_o,
    input  logic                 stream_m_ready_i,
    output logic                 irq_o,
    input  logic [4:0]           wbs_adr_i,
    input  logic [WB_DW-1:0]     wbs_dat_i,
    input  logic [WB_DW/8-1:0]   wbs_sel_i,
    input  logic                 wbs_we_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic [2:0]           wbs_cti_i,
    input  logic [1:0]           wbs_bte_i,
    output logic [WB_DW-1:0]     wbs_dat_o,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o
);
    localparam int WSB    = WB_DW / 8;
    localparam int WSB_LG = $clog2(WSB);
    localparam int DEPTH  = 2 ** FIFO_AW;
    localparam int CW     = WB_DW;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t             state, state_nxt;
    logic               busy, irq, err_flag;
    logic [WB_AW-1:0]   start_addr, adr;
    logic [CW-1:0]      buf_size, burst_size;
    logic [CW-1:0]      fetch_rem, beats, out_rem;
    logic [CW-1:0]      buf_words, burst_cap, len, free;
    logic [CW-1:0]      rd_data;

    logic [WB_DW-1:0]   mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;

    logic cfg_acc, cfg_wr, start_req, start_run;
    logic push, pop, burst_go, abort, err_hit, in_burst;
    logic unused_in;

`ifdef WB_STREAM_WRITER_ERR_EN
    assign err_hit   = wbm_err_i;
    assign unused_in = &{1'b0, wbs_sel_i, wbs_cti_i, wbs_bte_i};
`else
    assign err_hit   = 1'b0;
    assign unused_in = &{1'b0, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbm_err_i};
`endif

    // ---------------- configuration slave ----------------
    // The access is taken on the first cycle of cyc&stb; the registered ack
    // masks the second cycle so a held strobe is not taken twice.
    assign cfg_acc   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign cfg_wr    = cfg_acc & wbs_we_i;
    assign buf_words = buf_size >> WSB_LG;
    assign start_req = cfg_wr && (wbs_adr_i == 5'd0) && wbs_dat_i[0] && !busy;
    assign start_run = start_req && (buf_words != '0);
    assign wbs_err_o = 1'b0;
    assign irq_o     = irq;

    always_comb begin
        rd_data = '0;
        case (wbs_adr_i)
            5'd0:    rd_data[2:0] = {err_flag, irq, busy};
            5'd4:    rd_data = CW'(start_addr);
            5'd8:    rd_data = buf_size;
            5'd12:   rd_data = burst_size;
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            start_addr <= '0;
            buf_size   <= '0;
            burst_size <= '0;
            busy       <= 1'b0;
            irq        <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            wbs_ack_o <= cfg_acc;
            if (cfg_acc) wbs_dat_o <= rd_data;
            if (cfg_wr && !busy) begin
                case (wbs_adr_i)
                    5'd4:    start_addr <= wbs_dat_i[WB_AW-1:0];
                    5'd8:    buf_size   <= wbs_dat_i;
                    5'd12:   burst_size <= wbs_dat_i;
                    default: ;
                endcase
            end
            if (cfg_wr && (wbs_adr_i == 5'd0)) begin
                if (wbs_dat_i[1]) irq      <= 1'b0;
                if (wbs_dat_i[2]) err_flag <= 1'b0;
            end
            // An empty buffer completes on the spot.
            if (start_req) begin
                if (start_run) busy <= 1'b1;
                else           irq  <= 1'b1;
            end
            // Completion is tied to the stream side, not the fetch side.
            if (pop && (out_rem == CW'(1))) begin
                busy <= 1'b0;
                irq  <= 1'b1;
            end
            if (abort) begin
                busy     <= 1'b0;
                irq      <= 1'b1;
                err_flag <= 1'b1;
            end
        end
    end

    // ---------------- fetch FSM ----------------
    assign burst_cap = (burst_size == '0) ? CW'(1) :
                       (burst_size > CW'(MAX_BURST_LEN)) ? CW'(MAX_BURST_LEN) : burst_size;
    assign len       = (burst_cap < fetch_rem) ? burst_cap : fetch_rem;
    assign free      = CW'(DEPTH) - CW'(count);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_burst  = 1'b0;
        push      = 1'b0;
        burst_go  = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: if (start_run) state_nxt = WAIT;
            // Space for the whole burst is reserved up front, so acks are
            // never throttled once the cycle is on the bus.
            WAIT: if (free >= len) begin
                burst_go  = 1'b1;
                state_nxt = BURST;
            end
            BURST: begin
                in_burst = 1'b1;
                if (err_hit) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (wbm_ack_i) begin
                    push = 1'b1;
                    if (beats == CW'(1))
                        state_nxt = (fetch_rem == '0) ? IDLE : WAIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adr       <= '0;
            fetch_rem <= '0;
            beats     <= '0;
            out_rem   <= '0;
        end else begin
            if (start_run) begin
                adr       <= start_addr;
                fetch_rem <= buf_words;
                out_rem   <= buf_words;
            end else if (pop) begin
                out_rem <= out_rem - CW'(1);
            end
            if (burst_go) begin
                beats     <= len;
                fetch_rem <= fetch_rem - len;
            end
            if (push) begin
                beats <= beats - CW'(1);
                adr   <= adr + WB_AW'(WSB);    // wraps modulo 2**WB_AW
            end
        end
    end

    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_cti_o = !in_burst ? 3'b000 : (beats == CW'(1)) ? 3'b111 : 3'b010;
    assign wbm_adr_o = adr;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = 2'b00;

    // ---------------- output FIFO ----------------
    // valid comes from the occupancy register only, never from ready.
    assign stream_m_valid_o = (count != '0);
    assign stream_m_data_o  = mem[rd_ptr];
    assign pop              = stream_m_valid_o & stream_m_ready_i;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wbm_dat_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer
//   Self-checking bench for wb_stream_writer (default parameters). A behavioural
//   memory with random ack latency feeds the master port; a random-ready sink
//   collects the stream. Expected beats and data come from a burst-splitting
//   model of the register settings.
module tb_wb_stream_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] stream_m_data_o;
    logic        stream_m_valid_o, irq_o;
    logic        stream_m_ready_i = 1'b0;
    logic [4:0]  wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic        wbs_we_i = 1'b0, wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0;
    logic [2:0]  wbs_cti_i = 3'b000;
    logic [1:0]  wbs_bte_i = 2'b00;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o, wbs_err_o;

    always #5 clk = ~clk;

    wb_stream_writer dut (
        .clk(clk), .rst(rst),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
        .stream_m_ready_i(stream_m_ready_i), .irq_o(irq_o),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o)
    );

    int n_checks = 0, n_errors = 0;
    int max_dly = 0, ready_pct = 100, dly = 0, beat_idx = 0, err_at = -1;
    bit no_stab = 0;
    logic [31:0] got_data[$], exp_data[$], beat_adr[$], exp_adr[$];
    logic [2:0]  beat_cti[$], exp_cti[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    // Behavioural memory: combinational ack after a random number of stalls.
    logic hit;
    assign hit       = wbm_cyc_o && wbm_stb_o && (dly == 0);
    assign wbm_err_i = hit && (beat_idx == err_at);
    assign wbm_ack_i = hit && (beat_idx != err_at);
    assign wbm_dat_i = memw(wbm_adr_o);

    // Monitor: sample at negedge, drive at posedge+1.
    bit prev_final = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;
    always begin
        bit ak, er, cs;
        @(negedge clk);
        ak = wbm_ack_i; er = wbm_err_i; cs = wbm_cyc_o;
        if (rst) begin
            if (prev_final) begin
                n_checks++;
                if (wbm_cyc_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL cyc_drop: cyc=%b after final ack, required 0", wbm_cyc_o);
                end
            end
            if (prev_stall && !no_stab) begin
                n_checks++;
                if (stream_m_valid_o !== 1'b1 || stream_m_data_o !== prev_data) begin
                    n_errors++;
                    $display("FAIL stream_hold: valid=%b data=%h, required 1 %h",
                             stream_m_valid_o, stream_m_data_o, prev_data);
                end
            end
        end
        prev_final = ak && (wbm_cti_o == 3'b111);
        prev_stall = stream_m_valid_o && !stream_m_ready_i;
        prev_data  = stream_m_data_o;
        if (stream_m_valid_o && stream_m_ready_i) got_data.push_back(stream_m_data_o);
        if (ak) begin
            beat_adr.push_back(wbm_adr_o);
            beat_cti.push_back(wbm_cti_o);
        end
        @(posedge clk); #1;
        if (ak || er) begin
            beat_idx++;
            dly = $urandom_range(max_dly, 0);
        end else if (cs && dly > 0) begin
            dly--;
        end
        stream_m_ready_i = ($urandom_range(99, 0) < ready_pct);
    end

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(posedge clk); #1;
        wbs_we_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d, output logic ackv);
        @(posedge clk); #1;
        wbs_adr_i = a; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(posedge clk); #1;
        d = wbs_dat_o; ackv = wbs_ack_o;
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic wait_irq(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (irq_o) begin ok = 1; break; end
        end
    endtask

    // Reference: split the buffer into bursts of the clamped size.
    task automatic build_exp(input logic [31:0] sa, input int nbytes, input int bs);
        int rem, b, len;
        logic [31:0] a;
        exp_data.delete(); exp_adr.delete(); exp_cti.delete();
        got_data.delete(); beat_adr.delete(); beat_cti.delete();
        rem = nbytes / 4; a = sa;
        b = (bs == 0) ? 1 : (bs > 32 ? 32 : bs);
        for (int i = 0; i < rem; i++) exp_data.push_back(memw(sa + 32'(i * 4)));
        while (rem > 0) begin
            len = (b < rem) ? b : rem;
            for (int k = 0; k < len; k++) begin
                exp_adr.push_back(a);
                exp_cti.push_back((k == len - 1) ? 3'b111 : 3'b010);
                a += 32'd4;
            end
            rem -= len;
        end
    endtask

    function automatic int data_diff();
        int n = (got_data.size() > exp_data.size()) ? got_data.size() - exp_data.size()
                                                    : exp_data.size() - got_data.size();
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++)
            if (got_data[i] !== exp_data[i]) n++;
        return n;
    endfunction

    function automatic int beat_diff();
        int n = (beat_adr.size() > exp_adr.size()) ? beat_adr.size() - exp_adr.size()
                                                   : exp_adr.size() - beat_adr.size();
        for (int i = 0; i < exp_adr.size() && i < beat_adr.size(); i++)
            if (beat_adr[i] !== exp_adr[i] || beat_cti[i] !== exp_cti[i]) n++;
        return n;
    endfunction

    task automatic run_buf(input logic [31:0] sa, input int nbytes, input int bs, input string tag);
        bit ok; logic [31:0] d; logic av;
        build_exp(sa, nbytes, bs);
        wb_write(5'd4, sa); wb_write(5'd8, 32'(nbytes)); wb_write(5'd12, 32'(bs));
        wb_write(5'd0, 32'h1);
        wait_irq(5000, ok);
        n_checks++;
        if (!ok) begin n_errors++; $display("FAIL %s_timeout: irq never set", tag); end
        n_checks++;
        if (got_data.size() !== exp_data.size()) begin
            n_errors++;
            $display("FAIL %s_irq_time: words out at irq=%0d, required %0d", tag, got_data.size(), exp_data.size());
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (data_diff() != 0) begin
            n_errors++;
            $display("FAIL %s_data: %0d word errors (got %0d words), required 0 (%0d words)",
                     tag, data_diff(), got_data.size(), exp_data.size());
        end
        n_checks++;
        if (beat_diff() != 0) begin
            n_errors++;
            $display("FAIL %s_beats: %0d adr/cti errors (got %0d beats), required 0 (%0d beats)",
                     tag, beat_diff(), beat_adr.size(), exp_adr.size());
        end
        wb_read(5'd0, d, av);
        n_checks++;
        if (d[2:0] !== 3'b010) begin
            n_errors++; $display("FAIL %s_csr: csr=%h, required 2", tag, d);
        end
        wb_write(5'd0, 32'h2);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_errors++; $display("FAIL %s_irq_clear: irq=%b, required 0", tag, irq_o);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d; logic av;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_cti_o, stream_m_valid_o, irq_o, wbs_ack_o} !== 8'b0 ||
            wbm_adr_o !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: cyc=%b stb=%b cti=%b adr=%h valid=%b irq=%b ack=%b, required all 0",
                     wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_adr_o, stream_m_valid_o, irq_o, wbs_ack_o);
        end
        rst = 1'b1;
        n_checks++;
        if (wbm_we_o !== 1'b0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'hF ||
            wbm_bte_o !== 2'b00 || wbs_err_o !== 1'b0) begin
            n_errors++;
            $display("FAIL const_ports: we=%b dat=%h sel=%h bte=%b err=%b, required 0 0 f 0 0",
                     wbm_we_o, wbm_dat_o, wbm_sel_o, wbm_bte_o, wbs_err_o);
        end
        for (int r = 0; r < 4; r++) begin
            wb_read(5'(r * 4), d, av);
            n_checks++;
            if (d !== 32'h0 || av !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_reg%0d: data=%h ack=%b, required 0 1", r * 4, d, av);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (wbs_ack_o !== 1'b0) begin
            n_errors++; $display("FAIL ack_pulse: ack=%b one cycle later, required 0", wbs_ack_o);
        end
        wb_write(5'd16, 32'hDEAD_BEEF);
        wb_read(5'd16, d, av);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL unmapped_reg: data=%h, required 0", d);
        end
    endtask

    task automatic test_basic();
        max_dly = 0; ready_pct = 100;
        run_buf(32'h40, 32, 4, "basic");
        run_buf(32'h100, 20, 4, "tail");
        run_buf(32'hFFFF_FFF8, 16, 3, "wrap");
        run_buf(32'h80, 12, 0, "bs_zero");
        run_buf(32'h200, 0, 4, "empty");
    endtask

    task automatic test_backpressure();
        bit ok; logic [31:0] d; logic av;
        max_dly = 0; ready_pct = 0;
        build_exp(32'h1000, 256, 8);
        wb_write(5'd4, 32'h1000); wb_write(5'd8, 32'd256); wb_write(5'd12, 32'd8);
        wb_write(5'd0, 32'h1);
        repeat (300) @(posedge clk); #1;
        n_checks++;
        if (beat_adr.size() !== 32 || wbm_cyc_o !== 1'b0 || got_data.size() !== 0) begin
            n_errors++;
            $display("FAIL bp_stall: beats=%0d cyc=%b out=%0d, required 32 0 0",
                     beat_adr.size(), wbm_cyc_o, got_data.size());
        end
        wb_read(5'd0, d, av);
        n_checks++;
        if (d[1:0] !== 2'b01) begin
            n_errors++; $display("FAIL bp_busy: csr=%h, required busy only", d);
        end
        wb_write(5'd8, 32'd4);
        wb_read(5'd8, d, av);
        n_checks++;
        if (d !== 32'd256) begin
            n_errors++; $display("FAIL busy_write_ignored: buf_size=%0d, required 256", d);
        end
        ready_pct = 100;
        wait_irq(3000, ok);
        repeat (3) @(posedge clk);
        n_checks++;
        if (!ok || data_diff() != 0 || beat_diff() != 0) begin
            n_errors++;
            $display("FAIL bp_complete: irq=%b data_err=%0d beat_err=%0d, required 1 0 0",
                     ok, data_diff(), beat_diff());
        end
        wb_write(5'd0, 32'h2);
    endtask

    task automatic test_irq_pending();
        bit ok; logic [31:0] d; logic av;
        max_dly = 1; ready_pct = 100;
        build_exp(32'h2000, 16, 4);
        wb_write(5'd4, 32'h2000); wb_write(5'd8, 32'd16); wb_write(5'd12, 32'd4);
        wb_write(5'd0, 32'h1);
        wait_irq(2000, ok);
        repeat (3) @(posedge clk);
        build_exp(32'h3000, 64, 4);
        wb_write(5'd4, 32'h3000); wb_write(5'd8, 32'd64);
        wb_write(5'd0, 32'h1);
        wb_read(5'd0, d, av);
        n_checks++;
        if (d[1:0] !== 2'b11) begin
            n_errors++; $display("FAIL start_irq_pending: csr=%h, required busy+irq", d);
        end
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            wb_read(5'd0, d, av);
            if (!d[0]) begin ok = 1; break; end
        end
        n_checks++;
        if (!ok || d[1] !== 1'b1 || data_diff() != 0) begin
            n_errors++;
            $display("FAIL pending_done: done=%b irq=%b data_err=%0d, required 1 1 0", ok, d[1], data_diff());
        end
        wb_write(5'd0, 32'h2);
        n_checks++;
        if (irq_o !== 1'b0) begin
            n_errors++; $display("FAIL pending_clear: irq=%b, required 0", irq_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic av; bit seen;
        max_dly = 0; ready_pct = 100; dly = 0;
        build_exp(32'h4000, 64, 8);
        wb_write(5'd4, 32'h4000); wb_write(5'd8, 32'd64); wb_write(5'd12, 32'd8);
        wb_write(5'd0, 32'h1);
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (beat_adr.size() >= 2) begin seen = 1; break; end
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (!seen || wbm_cyc_o !== 1'b0 || stream_m_valid_o !== 1'b0 || irq_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: reached=%b cyc=%b valid=%b irq=%b, required 1 0 0 0",
                     seen, wbm_cyc_o, stream_m_valid_o, irq_o);
        end
        @(negedge clk); rst = 1'b1;
        wb_read(5'd0, d, av);
        n_checks++;
        if (d !== 32'h0) begin
            n_errors++; $display("FAIL reset_mid_csr: csr=%h, required 0", d);
        end
        run_buf(32'h5000, 40, 8, "after_reset");
    endtask

`ifdef WB_STREAM_WRITER_ERR_EN
    task automatic test_err();
        logic [31:0] d; logic av;
        max_dly = 0; ready_pct = 0; no_stab = 1;
        build_exp(32'h6000, 32, 4);
        @(posedge clk); #2; beat_idx = 0; err_at = 1; dly = 0;
        wb_write(5'd4, 32'h6000); wb_write(5'd8, 32'd32); wb_write(5'd12, 32'd4);
        wb_write(5'd0, 32'h1);
        repeat (30) @(posedge clk); #1;
        n_checks++;
        if (beat_adr.size() !== 1 || wbm_cyc_o !== 1'b0 || stream_m_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL err_stop: beats=%0d cyc=%b valid=%b, required 1 0 0",
                     beat_adr.size(), wbm_cyc_o, stream_m_valid_o);
        end
        wb_read(5'd0, d, av);
        n_checks++;
        if (d !== 32'h6) begin
            n_errors++; $display("FAIL err_csr: csr=%h, required 6", d);
        end
        ready_pct = 100;
        repeat (10) @(posedge clk);
        n_checks++;
        if (got_data.size() !== 0) begin
            n_errors++; $display("FAIL err_flush: words out=%0d, required 0", got_data.size());
        end
        err_at = -1;
        wb_write(5'd0, 32'h6);
        no_stab = 0;
    endtask
`endif

    task automatic test_random();
        logic [31:0] sa;
        max_dly = 5; ready_pct = 90;
        for (int n = 0; n < 1000; n++) begin
            sa = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFE0 | (32'($urandom_range(7, 0)) << 2))
                                             : ($urandom & 32'hFFFF_FFFC);
            run_buf(sa, 4 * $urandom_range(12, 0), $urandom_range(40, 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_irq_pending();
        test_reset_mid();
`ifdef WB_STREAM_WRITER_ERR_EN
        test_err();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
